// File: rtl/tt_um_librelane_pattern_gen_if.sv
// Tiny Tapeout user-tile pin bundle for the pattern generator.
// The master side drives the input pins; the slave side is the tile itself.
interface tt_um_librelane_pattern_gen_if;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   logic       ena;

   modport master (
      output ui_in,
      output uio_in,
      output ena,
      input  uo_out,
      input  uio_out,
      input  uio_oe
   );

   modport slave (
      input  ui_in,
      input  uio_in,
      input  ena,
      output uo_out,
      output uio_out,
      output uio_oe
   );
endinterface

// File: rtl/tt_um_librelane_pattern_gen.sv
// Pattern-generator tile: up/down counter, Galois LFSR or uio loopback with prescaler and seed load.
// Define PATTERN_GEN_LFSR_EN to build the LFSR mode; otherwise mode 10 counts up.
module tt_um_librelane_pattern_gen #(
   parameter int               CNT_W           = 16,
   parameter int               PRESCALE        = 1,
   parameter int               RST_SYNC_STAGES = 2,
   parameter logic [CNT_W-1:0] POLY            = CNT_W'(16'hB400)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   tt_um_librelane_pattern_gen_if.slave tile
);

   typedef enum logic [1:0] {
      MODE_UP   = 2'b00,
      MODE_DOWN = 2'b01,
      MODE_LFSR = 2'b10,
      MODE_LOOP = 2'b11
   } mode_e;

   localparam int         NBYTES   = CNT_W / 8;
   localparam logic [3:0] NBYTES_L = 4'(NBYTES);
   localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

   logic [RST_SYNC_STAGES-1:0] rst_sync;
   logic                       rst_i;

   logic        out_en;
   mode_e       mode;
   logic        run;
   logic        ld_raw;
   logic [2:0]  byte_sel;
   logic        sel_ok;

   logic [CNT_W-1:0] state;
   logic [CNT_W-1:0] state_next;
   logic [CNT_W-1:0] step_val;
   logic [7:0]       capture;
   logic [15:0]      pre_cnt;
   logic             tick;
   logic             ld_s1;
   logic             ld_s2;
   logic             ld_dly;
   logic             load_ok;
   logic [7:0]       rd_byte;
   logic             unused_ok;

   // Release of the core reset is delayed through a chain of flops clocked by clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync <= '0;
      end else begin
         rst_sync[0] <= 1'b1;
         for (int i = 1; i < RST_SYNC_STAGES; i++) begin
            rst_sync[i] <= rst_sync[i-1];
         end
      end
   end

   assign rst_i    = rst_sync[RST_SYNC_STAGES-1];
   assign out_en   = tile.ui_in[0];
   assign mode     = mode_e'(tile.ui_in[2:1]);
   assign run      = tile.ui_in[3];
   assign ld_raw   = tile.ui_in[4];
   assign byte_sel = tile.ui_in[7:5];
   assign sel_ok   = ({1'b0, byte_sel} < NBYTES_L);

   assign tick    = run && (pre_cnt == PRE_LAST);
   assign load_ok = ld_s2 && !ld_dly && !out_en && sel_ok;

   always_comb begin
      step_val = state;
      case (mode)
         MODE_UP:   step_val = state + CNT_W'(1);
         MODE_DOWN: step_val = state - CNT_W'(1);
`ifdef PATTERN_GEN_LFSR_EN
         // All-zero is the LFSR's lockup state, so it is kicked to 1.
         MODE_LFSR: begin
            if (state == '0) begin
               step_val = CNT_W'(1);
            end else begin
               step_val = (state >> 1) ^ (state[0] ? POLY : '0);
            end
         end
`else
         MODE_LFSR: step_val = state + CNT_W'(1);
`endif
         default:   step_val = state;
      endcase
   end

   // A seed load wins over a coincident step tick.
   always_comb begin
      state_next = state;
      if (load_ok) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (byte_sel == 3'(b)) begin
               state_next[b*8 +: 8] = tile.uio_in;
            end
         end
      end else if (tick) begin
         state_next = step_val;
      end
   end

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         state   <= '0;
         capture <= '0;
         pre_cnt <= '0;
         ld_s1   <= 1'b0;
         ld_s2   <= 1'b0;
         ld_dly  <= 1'b0;
      end else begin
         state  <= state_next;
         ld_s1  <= ld_raw;
         ld_s2  <= ld_s1;
         ld_dly <= ld_s2;
         if (run) begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? 16'd0 : pre_cnt + 16'd1;
         end
         if (tick && mode == MODE_LOOP) begin
            capture <= tile.uio_in;
         end
      end
   end

   always_comb begin
      rd_byte = 8'h00;
      if (mode == MODE_LOOP) begin
         rd_byte = capture;
      end else begin
         for (int b = 0; b < NBYTES; b++) begin
            if (byte_sel == 3'(b)) begin
               rd_byte = state[b*8 +: 8];
            end
         end
      end
   end

   // While rst_n is low the tile simply mirrors ui_in and releases the bidir pads.
   assign tile.uo_out  = !rst_n ? tile.ui_in : (out_en ? rd_byte : tile.uio_in);
   assign tile.uio_out = out_en ? state[7:0] : 8'h00;
   assign tile.uio_oe  = (rst_n && out_en) ? 8'hFF : 8'h00;

`ifdef PATTERN_GEN_LFSR_EN
   assign unused_ok = &{1'b0, tile.ena};
`else
   assign unused_ok = &{1'b0, tile.ena, POLY};
`endif

endmodule

// File: tb/tb_tt_um_librelane_pattern_gen.sv
// Bench for the pattern-generator tile: a PRESCALE=1 and a PRESCALE=4 instance share all pins
// and are compared every cycle against a spec-level model, plus directed scenario checks.
module tb_tt_um_librelane_pattern_gen;

   localparam int STAGES = 2;

   logic       clk;
   logic       rst_n;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic       ena;

   tt_um_librelane_pattern_gen_if b0 ();
   tt_um_librelane_pattern_gen_if b1 ();

   assign b0.ui_in  = ui_in;
   assign b0.uio_in = uio_in;
   assign b0.ena    = ena;
   assign b1.ui_in  = ui_in;
   assign b1.uio_in = uio_in;
   assign b1.ena    = ena;

   logic [7:0] uo [2];
   logic [7:0] uioo [2];
   logic [7:0] oe [2];

   assign uo[0]   = b0.uo_out;
   assign uo[1]   = b1.uo_out;
   assign uioo[0] = b0.uio_out;
   assign uioo[1] = b1.uio_out;
   assign oe[0]   = b0.uio_oe;
   assign oe[1]   = b1.uio_oe;

   tt_um_librelane_pattern_gen #(
      .CNT_W(16), .PRESCALE(1), .RST_SYNC_STAGES(STAGES), .POLY(16'hB400)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .tile(b0)
   );

   tt_um_librelane_pattern_gen #(
      .CNT_W(16), .PRESCALE(4), .RST_SYNC_STAGES(STAGES), .POLY(16'hB400)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .tile(b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Spec-level model state: one register value, capture and run-edge count per instance.
   logic [15:0] m_state [2];
   logic [7:0]  m_cap [2];
   int          m_runs [2];
   int          presc [2] = '{1, 4};
   int          rel_edges;
   bit          p1, p2, p3;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] mk_ui(bit oe_b, bit [1:0] md, bit rn, bit ld, bit [2:0] sel);
      return {sel, ld, rn, md, oe_b};
   endfunction

   function automatic logic [15:0] next_val(logic [15:0] s, bit [1:0] md);
      case (md)
         2'd0: return s + 16'd1;
         2'd1: return s - 16'd1;
`ifdef PATTERN_GEN_LFSR_EN
         2'd2: begin
            if (s == 16'd0) return 16'd1;
            return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
         end
`else
         2'd2: return s + 16'd1;
`endif
         default: return s;
      endcase
   endfunction

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         m_state[d] = '0;
         m_cap[d]   = '0;
         m_runs[d]  = 0;
      end
      rel_edges = 0;
      p1 = 0; p2 = 0; p3 = 0;
   endtask

   task automatic model_edge();
      bit active, load_ok, tick;
      int sel;
      if (rst_n) rel_edges++;
      active  = rst_n && (rel_edges > STAGES);
      sel     = int'(ui_in[7:5]);
      load_ok = active && p2 && !p3 && !ui_in[0] && (sel < 2);
      if (active) begin
         for (int d = 0; d < 2; d++) begin
            tick = ui_in[3] && ((m_runs[d] % presc[d]) == presc[d] - 1);
            if (ui_in[3]) m_runs[d]++;
            if (tick && ui_in[2:1] == 2'd3) m_cap[d] = uio_in;
            if (load_ok) m_state[d][sel*8 +: 8] = uio_in;
            else if (tick) m_state[d] = next_val(m_state[d], ui_in[2:1]);
         end
      end
      p3 = p2;
      p2 = p1;
      p1 = active ? ui_in[4] : 1'b0;
   endtask

   task automatic checkOutput(input string tag);
      logic [7:0] rd, e_uo, e_uioo, e_oe;
      int sel;
      sel = int'(ui_in[7:5]);
      for (int d = 0; d < 2; d++) begin
         if (ui_in[2:1] == 2'd3) rd = m_cap[d];
         else if (sel < 2) rd = m_state[d][sel*8 +: 8];
         else rd = 8'h00;
         e_uo   = !rst_n ? ui_in : (ui_in[0] ? rd : uio_in);
         e_uioo = ui_in[0] ? m_state[d][7:0] : 8'h00;
         e_oe   = (rst_n && ui_in[0]) ? 8'hFF : 8'h00;
         cmp($sformatf("%s dut%0d uo_out", tag, d), {24'd0, uo[d]}, {24'd0, e_uo});
         cmp($sformatf("%s dut%0d uio_out", tag, d), {24'd0, uioo[d]}, {24'd0, e_uioo});
         cmp($sformatf("%s dut%0d uio_oe", tag, d), {24'd0, oe[d]}, {24'd0, e_oe});
      end
   endtask

   task automatic applyStimulus(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      checkOutput(tag);
   endtask

   // Reads the full 16-bit state of the PRESCALE=1 instance through the readout mux, between edges.
   task automatic peek_state(output logic [15:0] v);
      logic [7:0] saved;
      saved = ui_in;
      ui_in = {3'd0, saved[4], 1'b0, 2'b00, 1'b1};
      #1 v[7:0] = uo[0];
      ui_in[7:5] = 3'd1;
      #1 v[15:8] = uo[0];
      ui_in = saved;
   endtask

   task automatic do_load(input bit [2:0] sel, input logic [7:0] val);
      ui_in  = mk_ui(0, ui_in[2:1], 0, 0, sel);
      uio_in = val;
      applyStimulus("load_idle");
      ui_in[4] = 1'b1;
      repeat (3) applyStimulus("load_strobe");
      ui_in[4] = 1'b0;
      applyStimulus("load_done");
   endtask

   task automatic edges_to_change(input int drop_at, output int n);
      logic [7:0] prev;
      prev = uo[1];
      n = -1;
      for (int i = 1; i <= 20; i++) begin
         applyStimulus("presc");
         if (uo[1] !== prev) begin
            n = i;
            return;
         end
         if (i == drop_at) ui_in[3] = 1'b0;
         if (i == drop_at + 3) ui_in[3] = 1'b1;
      end
   endtask

   initial begin
      logic [15:0] vb, va;
      logic [15:0] lfsr_exp [3];
      int gap;

      ena    = 1'b1;
      uio_in = 8'h00;
      ui_in  = mk_ui(1, 2'd0, 1, 0, 3'd0);
      rst_n  = 1'b0;
      model_clear();

      // Reset hold and release count-up
      repeat (5) begin
         applyStimulus("rst_hold");
         cmp("rst uo_out=ui_in", {24'd0, uo[0]}, 32'h09);
         cmp("rst uio_oe", {24'd0, oe[0]}, 32'h00);
      end
      rst_n = 1'b1;
      #1 cmp("release uio_oe", {24'd0, oe[0]}, 32'hFF);
      applyStimulus("rel1"); cmp("edge1 uo_out", {24'd0, uo[0]}, 32'h00);
      applyStimulus("rel2"); cmp("edge2 uo_out", {24'd0, uo[0]}, 32'h00);
      applyStimulus("rel3"); cmp("edge3 uo_out", {24'd0, uo[0]}, 32'h01);
      applyStimulus("rel4"); cmp("edge4 uo_out", {24'd0, uo[0]}, 32'h02);
      repeat (3) applyStimulus("run");

      // Asynchronous reset in mid-operation
      #1 rst_n = 1'b0;
      model_clear();
      #1 checkOutput("midrst");
      cmp("midrst uio_out cleared", {24'd0, uioo[0]}, 32'h00);
      repeat (2) applyStimulus("midrst_hold");
      rst_n = 1'b1;
      ui_in = mk_ui(0, 2'd0, 0, 0, 3'd0);
      repeat (3) applyStimulus("midrst_rel");

      // Wrap up and down
      do_load(3'd0, 8'hFF);
      do_load(3'd1, 8'hFF);
      peek_state(va); cmp("seed FFFF", {16'd0, va}, 32'hFFFF);
      ui_in = mk_ui(0, 2'd0, 1, 0, 3'd0);
      applyStimulus("wrap_up");
      ui_in[3] = 1'b0;
      peek_state(va); cmp("up wrap", {16'd0, va}, 32'h0000);
      ui_in = mk_ui(0, 2'd1, 1, 0, 3'd0);
      applyStimulus("wrap_down");
      ui_in[3] = 1'b0;
      peek_state(va); cmp("down wrap", {16'd0, va}, 32'hFFFF);

      // Prescaler spacing on the PRESCALE=4 instance
      ui_in = mk_ui(1, 2'd0, 1, 0, 3'd0);
      edges_to_change(0, gap);
      cmp("presc sync found", {31'd0, gap > 0}, 32'd1);
      edges_to_change(0, gap); cmp("presc gap a", gap, 32'd4);
      edges_to_change(0, gap); cmp("presc gap b", gap, 32'd4);
      edges_to_change(1, gap); cmp("presc gap run dropped", gap, 32'd7);

      // Load coincident with a tick: byte written, no step
      ui_in  = mk_ui(0, 2'd0, 1, 0, 3'd1);
      uio_in = 8'hA5;
      applyStimulus("ld_tick_idle");
      ui_in[4] = 1'b1;
      applyStimulus("ld_tick_k");
      applyStimulus("ld_tick_k1");
      peek_state(vb);
      applyStimulus("ld_tick_k2");
      peek_state(va);
      cmp("load beats tick", {16'd0, va}, {16'd0, 8'hA5, vb[7:0]});
      ui_in[4] = 1'b0;
      applyStimulus("ld_tick_end");

      // Filtered loads: out_en set, then byte select out of range
      ui_in  = mk_ui(1, 2'd0, 0, 0, 3'd1);
      uio_in = 8'h5A;
      applyStimulus("flt_oe_idle");
      peek_state(vb);
      ui_in[4] = 1'b1;
      repeat (3) applyStimulus("flt_oe");
      peek_state(va); cmp("load dropped out_en", {16'd0, va}, {16'd0, vb});
      ui_in = mk_ui(0, 2'd0, 0, 0, 3'd5);
      applyStimulus("flt_sel_idle");
      ui_in[4] = 1'b1;
      repeat (3) applyStimulus("flt_sel");
      peek_state(va); cmp("load dropped sel5", {16'd0, va}, {16'd0, vb});
      ui_in[4] = 1'b0;
      applyStimulus("flt_end");

      // Mode 10 from seeds 0001 and 0000
`ifdef PATTERN_GEN_LFSR_EN
      lfsr_exp = '{16'hB400, 16'h5A00, 16'h2D00};
`else
      lfsr_exp = '{16'h0002, 16'h0003, 16'h0004};
`endif
      do_load(3'd0, 8'h01);
      do_load(3'd1, 8'h00);
      peek_state(va); cmp("lfsr seed", {16'd0, va}, 32'h0001);
      for (int i = 0; i < 3; i++) begin
         ui_in = mk_ui(0, 2'd2, 1, 0, 3'd0);
         applyStimulus("lfsr_step");
         ui_in[3] = 1'b0;
         peek_state(va);
         cmp($sformatf("lfsr step %0d", i), {16'd0, va}, {16'd0, lfsr_exp[i]});
      end
      do_load(3'd0, 8'h00);
      do_load(3'd1, 8'h00);
      ui_in = mk_ui(0, 2'd2, 1, 0, 3'd0);
      applyStimulus("lfsr_zero");
      ui_in[3] = 1'b0;
      peek_state(va); cmp("lfsr zero kick", {16'd0, va}, 32'h0001);

      // Loopback capture
      peek_state(vb);
      ui_in  = mk_ui(1, 2'd3, 1, 0, 3'd0);
      uio_in = 8'h3C;
      applyStimulus("loop");
      cmp("loop uo_out", {24'd0, uo[0]}, 32'h3C);
      cmp("loop uio_out", {24'd0, uioo[0]}, {24'd0, vb[7:0]});
      ui_in[3] = 1'b0;
      peek_state(va); cmp("loop state held", {16'd0, va}, {16'd0, vb});

      // Randomised traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         ui_in  = 8'($urandom);
         uio_in = 8'($urandom);
         if ($urandom_range(0, 79) == 0) begin
            rst_n = 1'b0;
            model_clear();
            #1 checkOutput("rnd_rst");
            repeat (2) applyStimulus("rnd_rst_hold");
            rst_n = 1'b1;
         end
         applyStimulus("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
